pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the RV32I 5-stage pipeline. It drives the enable and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch redirects, instruction- and data-memory wait states, and a debug halt/drain/resume sequence. It also keeps saturating performance counters for stall cycles and flush events.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter
- DRAIN_CYCLES, 4, number of cycles fetch is blocked before `halted` asserts (IF/ID through MEM/WB)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rd  in  5  destination of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch or jump resolved taken in EX
- imem_ready  in  1  instruction fetch data valid this cycle
- mem_req  in  1  MEM stage has an outstanding data access
- dmem_ready  in  1  data access completes this cycle
- halt_req  in  1  debug halt request (pulse or level)
- resume_req  in  1  debug resume request
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register load enables
- if_id_flush, id_ex_flush, mem_wb_flush  out  1  insert a bubble (NOP / valid=0)
- halted  out  1  pipeline drained and frozen
- stall_cnt, flush_cnt  out  CNT_W  saturating performance counters

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- Control outputs are combinational from the current state and inputs. Default: all enables are 1 and all flushes are 0.
- Conditions are evaluated in strict priority order; the first true condition applies:
  1. dmem_wait = mem_req & !dmem_ready: all five enables are 0 and mem_wb_flush is 1.
  2. ex_branch_taken: pc_en is 1 (loads the target), if_id_flush is 1, id_ex_flush is 1.
  3. load_use = ex_mem_read & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)): pc_en is 0, if_id_en is 0, id_ex_flush is 1.
  4. Fetch blocked, meaning !imem_ready or state≠RUN: pc_en is 0 and if_id_flush is 1.
- A register x0 destination never produces a hazard.
- RUN → DRAIN when halt_req is sampled high. The drain counter loads DRAIN_CYCLES.
- In DRAIN, the counter decrements once per cycle in which dmem_wait is 0. At zero the FSM moves to HALTED.
- In HALTED, all enables are 0 and `halted` is 1. resume_req moves the FSM to RUN.
- resume_req outside HALTED is ignored. halt_req outside RUN is ignored.
- stall_cnt increments on each cycle where dmem_wait, load_use or !imem_ready applies in RUN. It does not count in HALTED.
- flush_cnt increments on each cycle in which ex_branch_taken applies.
- Both counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- Stall/flush decisions take effect in the same cycle: zero latency from inputs to outputs.
- A load-use stall lasts exactly one cycle, because the injected bubble clears ex_mem_read in the next cycle.
- `halted` is registered. It rises the cycle after the drain counter reaches 0, which is DRAIN_CYCLES+1 cycles after halt_req with no data waits.
- `halted` falls the cycle after resume_req. Fetch resumes in that same cycle.
- halt_req together with ex_branch_taken: the branch flush still applies that cycle and DRAIN starts next cycle.
- halt_req during dmem_wait: the FSM enters DRAIN, but the counter holds until the wait clears.
- Counters update on clock edges. Values are visible the cycle after the event.
- Reset (asynchronous, at any time including mid-DRAIN or HALTED):
  - state goes to RUN and the drain counter to 0;
  - stall_cnt and flush_cnt go to 0;
  - halted goes to 0.
  - Combinational outputs then follow the RUN defaults: all enables 1 and all flushes 0 unless the inputs assert a hazard.

## Structure
- Shared package `rv_pipe_pkg` holds:
  - state encodings (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2);
  - REG_ADDR_W=5;
  - the NOP encoding 32'h00000013, used by the flush consumers.
- Sub-module `sat_counter` (parameter W; ports clk, rst_n, inc, count) is instantiated twice, for stall_cnt and flush_cnt.
- Hazard compare logic and the FSM stay in the top module.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt goes 0→1.
- x0 load: ex_mem_read=1, ex_rd=0, id_rs1=0, id_use_rs1=1 → no stall; all enables 1.
- Branch and load-use in the same cycle → pc_en=1, if_id_flush=1, id_ex_flush=1, if_id_en=1; flush_cnt=1, stall_cnt=0.
- mem_req=1 with dmem_ready=0 for 3 cycles, together with ex_branch_taken=1 → all enables 0 and mem_wb_flush=1 for 3 cycles; stall_cnt=3, flush_cnt=0.
- halt_req pulse, no waits → pc_en=0 and if_id_flush=1 for 4 cycles; halted=1 on the 5th cycle. resume_req → halted=0 next cycle and pc_en=1. Reset asserted mid-DRAIN → RUN with counters at 0.
- CNT_W=4 with 20 consecutive imem_ready=0 cycles → stall_cnt holds at 15.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32I 5-stage pipeline control blocks.
package rv_pipe_pkg;

  // Hazard controller FSM encodings
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Register file address width
  localparam int REG_ADDR_W = 5;

  // addi x0, x0, 0 -- the bubble injected by flush consumers
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count events, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use, branch redirect, memory waits
// and the debug halt/drain/resume sequence, plus performance counters.
module pipe_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  imem_ready,
  input  logic                  mem_req,
  input  logic                  dmem_ready,
  input  logic                  halt_req,
  input  logic                  resume_req,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_flush,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int DCW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_t         state_reg;
  logic [DCW-1:0] drain_cnt_reg;
  logic           halted_reg;

  logic dmem_wait;
  logic load_use;
  logic fetch_blocked;
  logic stall_inc;
  logic flush_inc;

  assign dmem_wait     = mem_req & ~dmem_ready;
  // x0 is hardwired to zero, so a load targeting it never creates a hazard
  assign load_use      = ex_mem_read & (ex_rd != '0) &
                         ((id_use_rs1 & (id_rs1 == ex_rd)) |
                          (id_use_rs2 & (id_rs2 == ex_rd)));
  assign fetch_blocked = ~imem_ready | (state_reg != ST_RUN);

  // Prioritised enable/flush selection; HALTED freezes every register
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (state_reg == ST_HALTED) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (dmem_wait) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (fetch_blocked) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // Only the condition that actually won the priority contest is counted
  assign stall_inc = (state_reg == ST_RUN) &
                     (dmem_wait | (~ex_branch_taken & (load_use | ~imem_ready)));
  assign flush_inc = (state_reg != ST_HALTED) & ~dmem_wait & ex_branch_taken;

  // Halt/drain/resume FSM with registered halted flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      drain_cnt_reg <= '0;
      halted_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (halt_req) begin
            state_reg     <= ST_DRAIN;
            drain_cnt_reg <= DCW'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          // A stalled MEM stage is not draining, so the count holds
          if (!dmem_wait) begin
            if (drain_cnt_reg <= DCW'(1)) begin
              drain_cnt_reg <= '0;
              state_reg     <= ST_HALTED;
              halted_reg    <= 1'b1;
            end else begin
              drain_cnt_reg <= drain_cnt_reg - DCW'(1);
            end
          end
        end
        ST_HALTED: begin
          if (resume_req) begin
            state_reg  <= ST_RUN;
            halted_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ST_RUN;
          drain_cnt_reg <= '0;
          halted_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign halted = halted_reg;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed literal checks plus a
// randomized run compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, ex_branch_taken = 0;
  logic       imem_ready = 1, mem_req = 0, dmem_ready = 0, halt_req = 0, resume_req = 0;

  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, mem_wb_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic        b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en;
  logic        b_if_id_flush, b_id_ex_flush, b_mem_wb_flush, b_halted;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16), .DRAIN_CYCLES(4)) u_a (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .imem_ready(imem_ready), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .halt_req(halt_req), .resume_req(resume_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(4), .DRAIN_CYCLES(4)) u_b (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .imem_ready(imem_ready), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .halt_req(halt_req), .resume_req(resume_req),
    .pc_en(b_pc_en), .if_id_en(b_if_id_en), .id_ex_en(b_id_ex_en),
    .ex_mem_en(b_ex_mem_en), .mem_wb_en(b_mem_wb_en),
    .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush),
    .mem_wb_flush(b_mem_wb_flush), .halted(b_halted),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 running, 1 draining, 2 halted
  int m_mode = 0, m_left = 0;
  int m_stall16 = 0, m_flush16 = 0, m_stall4 = 0, m_flush4 = 0;

  // Every cycle: predict outputs from the rules, compare, then advance model
  always @(negedge clk) begin
    int  cause;
    bit  dw, lu;
    logic [4:0] exp_en;
    logic [2:0] exp_fl;
    if (!rst_n) begin
      m_mode = 0; m_left = 0;
      m_stall16 = 0; m_flush16 = 0; m_stall4 = 0; m_flush4 = 0;
    end
    dw = mem_req && !dmem_ready;
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    // cause: 0 none, 1 data wait, 2 branch, 3 load-use, 4 fetch blocked, 5 frozen
    if (m_mode == 2)                    cause = 5;
    else if (dw)                        cause = 1;
    else if (ex_branch_taken)           cause = 2;
    else if (lu)                        cause = 3;
    else if (!imem_ready || m_mode != 0) cause = 4;
    else                                cause = 0;
    // enables {pc, if_id, id_ex, ex_mem, mem_wb}; flushes {if_id, id_ex, mem_wb}
    case (cause)
      1: begin exp_en = 5'b00000; exp_fl = 3'b001; end
      2: begin exp_en = 5'b11111; exp_fl = 3'b110; end
      3: begin exp_en = 5'b00111; exp_fl = 3'b010; end
      4: begin exp_en = 5'b01111; exp_fl = 3'b100; end
      5: begin exp_en = 5'b00000; exp_fl = 3'b000; end
      default: begin exp_en = 5'b11111; exp_fl = 3'b000; end
    endcase
    chk("enables", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, exp_en);
    chk("flushes", {if_id_flush, id_ex_flush, mem_wb_flush}, exp_fl);
    chk("b_enables", {b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en}, exp_en);
    chk("b_flushes", {b_if_id_flush, b_id_ex_flush, b_mem_wb_flush}, exp_fl);
    chk("halted", halted, m_mode == 2);
    chk("b_halted", b_halted, m_mode == 2);
    chk("stall_cnt", stall_cnt, m_stall16);
    chk("flush_cnt", flush_cnt, m_flush16);
    chk("b_stall_cnt", b_stall_cnt, m_stall4);
    chk("b_flush_cnt", b_flush_cnt, m_flush4);
    if (rst_n) begin
      if (m_mode == 0 && cause != 0 && cause != 2) begin
        if (m_stall16 < 65535) m_stall16++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (cause == 2) begin
        if (m_flush16 < 65535) m_flush16++;
        if (m_flush4 < 15) m_flush4++;
      end
      case (m_mode)
        0: if (halt_req) begin m_mode = 1; m_left = 4; end
        1: if (!dw) begin
             m_left--;
             if (m_left <= 0) begin m_left = 0; m_mode = 2; end
           end
        default: if (resume_req) m_mode = 0;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_mem_read = 0; ex_branch_taken = 0; imem_ready = 1; mem_req = 0;
    dmem_ready = 0; halt_req = 0; resume_req = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #1;
    cyc();
    #1;
    chk("rst_halted", halted, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_pc_en", pc_en, 1);
    do_reset();

    // load-use on rs1
    cyc();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    #1;
    chk("lu_pc_en", pc_en, 0);
    chk("lu_if_id_en", if_id_en, 0);
    chk("lu_id_ex_flush", id_ex_flush, 1);
    cyc(); idle(); #1;
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_after_pc_en", pc_en, 1);

    // x0 load destination
    do_reset();
    cyc();
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    #1;
    chk("x0_enables", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b11111);
    cyc(); idle(); #1;
    chk("x0_stall_cnt", stall_cnt, 0);

    // branch beats load-use
    do_reset();
    cyc();
    ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    #1;
    chk("br_pc_en", pc_en, 1);
    chk("br_if_id_en", if_id_en, 1);
    chk("br_if_id_flush", if_id_flush, 1);
    chk("br_id_ex_flush", id_ex_flush, 1);
    cyc(); idle(); #1;
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 0);

    // data wait beats branch for 3 cycles
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      mem_req = 1; dmem_ready = 0; ex_branch_taken = 1;
      #1;
      chk("dw_enables", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b00000);
      chk("dw_mem_wb_flush", mem_wb_flush, 1);
    end
    cyc(); idle(); #1;
    chk("dw_stall_cnt", stall_cnt, 3);
    chk("dw_flush_cnt", flush_cnt, 0);

    // halt pulse, drain, halt, resume
    do_reset();
    cyc(); halt_req = 1;
    cyc(); halt_req = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("drain_pc_en", pc_en, 0);
      chk("drain_if_id_flush", if_id_flush, 1);
      chk("drain_halted", halted, 0);
      cyc();
    end
    #1;
    chk("halt_halted", halted, 1);
    chk("halt_pc_en", pc_en, 0);
    cyc(); resume_req = 1; #1;
    chk("resume_halted_still", halted, 1);
    cyc(); resume_req = 0; #1;
    chk("resume_halted", halted, 0);
    chk("resume_pc_en", pc_en, 1);

    // reset in the middle of DRAIN
    do_reset();
    cyc(); imem_ready = 0;
    cyc(); imem_ready = 1; halt_req = 1;
    cyc(); halt_req = 0;
    cyc();
    #1;
    chk("middrain_stall_before", stall_cnt, 1);
    rst_n = 0; #1;
    chk("middrain_rst_stall", stall_cnt, 0);
    chk("middrain_rst_pc_en", pc_en, 1);
    chk("middrain_rst_halted", halted, 0);
    cyc(); rst_n = 1;
    for (int i = 0; i < 6; i++) cyc();
    #1;
    chk("middrain_after_halted", halted, 0);
    chk("middrain_after_pc_en", pc_en, 1);

    // saturation of the 4-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(); imem_ready = 0;
    end
    cyc(); idle(); #1;
    chk("sat_b_stall_cnt", b_stall_cnt, 15);
    chk("sat_a_stall_cnt", stall_cnt, 20);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst_n           = ($urandom_range(0, 299) != 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      imem_ready      = ($urandom_range(0, 4) != 0);
      mem_req         = ($urandom_range(0, 2) == 0);
      dmem_ready      = 1'($urandom_range(0, 1));
      halt_req        = ($urandom_range(0, 39) == 0);
      resume_req      = ($urandom_range(0, 7) == 0);
    end
    cyc(); idle(); rst_n = 1;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
